// File: rtl/c_unary_stream_if.sv
// Stream bundle for c_unary_stream: beat input channel, abort and verdict output channel.
//   slave  : the detector side (consumes beats, produces verdicts)
//   master : the producer/consumer side driving beats and accepting verdicts
interface c_unary_stream_if #(
    parameter int unsigned P_W      = 32,
    parameter int unsigned P_BEAT_W = 8
);
    localparam int unsigned CNT_W = $clog2(P_W + 1);

    logic                i_in_vld;
    logic                o_in_rdy;
    logic [P_BEAT_W-1:0] i_in_dat;
    logic                i_abort;
    logic                o_out_vld;
    logic                i_out_rdy;
    logic                o_out_is_unary;
    logic                o_out_is_unary_n;
    logic [CNT_W-1:0]    o_out_count;

    modport slave (
        input  i_in_vld, i_in_dat, i_abort, i_out_rdy,
        output o_in_rdy, o_out_vld, o_out_is_unary, o_out_is_unary_n, o_out_count
    );

    modport master (
        output i_in_vld, i_in_dat, i_abort, i_out_rdy,
        input  o_in_rdy, o_out_vld, o_out_is_unary, o_out_is_unary_n, o_out_count
    );
endinterface

// File: rtl/c_unary_stream.sv
// Multi-beat unary (thermometer) code detector.
// A P_W-bit vector arrives as P_W/P_BEAT_W beats, LSB beat first. Edge state is
// accumulated across beats; after the final beat a registered verdict reports
// whether the vector is unary (0..01..1), complemented unary (1..10..0) and its
// run length.
// Ports:
//   clk, arst_n   clock, asynchronous active-low reset
//   bus (slave)   i_in_vld/o_in_rdy/i_in_dat beat channel, i_abort,
//                 o_out_vld/i_out_rdy verdict channel with
//                 o_out_is_unary, o_out_is_unary_n, o_out_count
module c_unary_stream #(
    parameter int unsigned P_W                   = 32,
    parameter int unsigned P_BEAT_W              = 8,
    parameter bit          P_ADMIT_COMPLIMENT_EN = 1'b1
) (
    input  logic              clk,
    input  logic              arst_n,
    c_unary_stream_if.slave   bus
);
    localparam int unsigned N       = P_W / P_BEAT_W;
    localparam int unsigned BEAT_CW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned CNT_W   = $clog2(P_W + 1);
    localparam logic [BEAT_CW-1:0] LAST_BEAT = BEAT_CW'(N - 1);

    // accumulator
    logic [BEAT_CW-1:0] beat_q;
    logic               seen0_q, bad_q;
    logic               seen1_q, bad_n_q;
    logic [CNT_W-1:0]   cnt1_q, cnt0_q;

    // output register
    logic               out_vld_q;
    logic               out_u_q, out_un_q;
    logic [CNT_W-1:0]   out_cnt_q;

    // scan results for the current beat
    logic               seen0_nx, bad_nx;
    logic               seen1_nx, bad_n_nx;
    logic [CNT_W-1:0]   cnt1_nx, cnt0_nx;

    // verdict candidates
    logic               v_u, v_un;
    logic [CNT_W-1:0]   v_cnt;

    logic               in_rdy_c, accept_c, last_c;

    assign in_rdy_c = ~out_vld_q | bus.i_out_rdy;
    assign accept_c = bus.i_in_vld & in_rdy_c & ~bus.i_abort;
    assign last_c   = (beat_q == LAST_BEAT);

    // LSB->MSB scan of the beat, seeded from the accumulator
    always_comb begin
        seen0_nx = seen0_q;
        bad_nx   = bad_q;
        cnt1_nx  = cnt1_q;
        seen1_nx = seen1_q;
        bad_n_nx = bad_n_q;
        cnt0_nx  = cnt0_q;
        for (int i = 0; i < int'(P_BEAT_W); i++) begin
            if (bus.i_in_dat[i]) begin
                if (seen0_nx) bad_nx  = 1'b1;
                else          cnt1_nx = cnt1_nx + CNT_W'(1);
                seen1_nx = 1'b1;
            end else begin
                if (seen1_nx) bad_n_nx = 1'b1;
                else          cnt0_nx  = cnt0_nx + CNT_W'(1);
                seen0_nx = 1'b1;
            end
        end
    end

    // verdict; unary wins when both hold (all-zeros / all-ones)
    always_comb begin
        v_u   = ~bad_nx;
        v_un  = ~bad_n_nx & P_ADMIT_COMPLIMENT_EN;
        v_cnt = '0;
        if (v_u)       v_cnt = cnt1_nx;
        else if (v_un) v_cnt = cnt0_nx;
    end

    // accumulator: abort and final beat both return it to the reset value
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            beat_q  <= '0;
            seen0_q <= 1'b0;
            bad_q   <= 1'b0;
            cnt1_q  <= '0;
            seen1_q <= 1'b0;
            bad_n_q <= 1'b0;
            cnt0_q  <= '0;
        end else if (bus.i_abort || (accept_c && last_c)) begin
            beat_q  <= '0;
            seen0_q <= 1'b0;
            bad_q   <= 1'b0;
            cnt1_q  <= '0;
            seen1_q <= 1'b0;
            bad_n_q <= 1'b0;
            cnt0_q  <= '0;
        end else if (accept_c) begin
            beat_q  <= beat_q + BEAT_CW'(1);
            seen0_q <= seen0_nx;
            bad_q   <= bad_nx;
            cnt1_q  <= cnt1_nx;
            seen1_q <= seen1_nx;
            bad_n_q <= bad_n_nx;
            cnt0_q  <= cnt0_nx;
        end
    end

    // output register: reload beats drain, fields held otherwise
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            out_vld_q <= 1'b0;
            out_u_q   <= 1'b0;
            out_un_q  <= 1'b0;
            out_cnt_q <= '0;
        end else if (accept_c && last_c) begin
            out_vld_q <= 1'b1;
            out_u_q   <= v_u;
            out_un_q  <= v_un;
            out_cnt_q <= v_cnt;
        end else if (bus.i_out_rdy) begin
            out_vld_q <= 1'b0;
        end
    end

    assign bus.o_in_rdy         = in_rdy_c;
    assign bus.o_out_vld        = out_vld_q;
    assign bus.o_out_is_unary   = out_u_q;
    assign bus.o_out_is_unary_n = out_un_q;
    assign bus.o_out_count      = out_cnt_q;
endmodule

// File: tb/tb_c_unary_stream.sv
// Scoreboard bench for c_unary_stream (P_W=16, P_BEAT_W=4), with the
// complement detector enabled on one instance and disabled on the other.
module tb_c_unary_stream;
    localparam int unsigned W  = 16;
    localparam int unsigned BW = 4;
    localparam int unsigned NB = W / BW;

    typedef struct packed {
        logic       u;
        logic       un;
        logic [4:0] cnt;
    } verdict_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_vld;
    logic [BW-1:0] in_dat;
    logic          abort;
    logic          out_rdy;

    int n_cmp = 0;
    int n_err = 0;

    verdict_t q_en[$];
    verdict_t q_dis[$];

    logic [W-1:0] m_vec;
    int           m_beat;
    int           cyc = 0;
    int           last_cyc;
    bit           gap_on = 1'b0;

    always #5 clk = ~clk;

    c_unary_stream_if #(.P_W(W), .P_BEAT_W(BW)) bus_en ();
    c_unary_stream_if #(.P_W(W), .P_BEAT_W(BW)) bus_dis ();

    assign bus_en.i_in_vld   = in_vld;
    assign bus_en.i_in_dat   = in_dat;
    assign bus_en.i_abort    = abort;
    assign bus_en.i_out_rdy  = out_rdy;
    assign bus_dis.i_in_vld  = in_vld;
    assign bus_dis.i_in_dat  = in_dat;
    assign bus_dis.i_abort   = abort;
    assign bus_dis.i_out_rdy = out_rdy;

    c_unary_stream #(.P_W(W), .P_BEAT_W(BW), .P_ADMIT_COMPLIMENT_EN(1'b1)) dut_en (
        .clk    (clk),
        .arst_n (rst_n),
        .bus    (bus_en)
    );

    c_unary_stream #(.P_W(W), .P_BEAT_W(BW), .P_ADMIT_COMPLIMENT_EN(1'b0)) dut_dis (
        .clk    (clk),
        .arst_n (rst_n),
        .bus    (bus_dis)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // reference by closed form: x is unary iff x & (x+1) == 0
    function automatic verdict_t ref_verdict(input logic [W-1:0] v, input bit en);
        verdict_t     r;
        logic [W:0]   a, b;
        logic [W-1:0] nv;
        nv    = ~v;
        a     = {1'b0, v};
        b     = {1'b0, nv};
        r.u   = ((a & (a + 17'd1)) == 17'd0);
        r.un  = en && ((b & (b + 17'd1)) == 17'd0);
        r.cnt = '0;
        if (r.u)       r.cnt = 5'($countones(v));
        else if (r.un) r.cnt = 5'($countones(nv));
        return r;
    endfunction

    // monitor: model beat assembly and compare every accepted verdict
    always @(negedge clk) begin
        verdict_t e;
        cyc++;
        if (!gap_on) last_cyc = -1;
        if (!rst_n) begin
            m_beat = 0;
            m_vec  = '0;
            q_en.delete();
            q_dis.delete();
        end else begin
            if (bus_en.o_out_vld && out_rdy) begin
                if (q_en.size() == 0 || q_dis.size() == 0) begin
                    check_val("unexpected_verdict", 32'd1, 32'd0);
                end else begin
                    e = q_en.pop_front();
                    check_val("en_is_unary",   bus_en.o_out_is_unary,   e.u);
                    check_val("en_is_unary_n", bus_en.o_out_is_unary_n, e.un);
                    check_val("en_count",      bus_en.o_out_count,      e.cnt);
                    e = q_dis.pop_front();
                    check_val("dis_vld",        bus_dis.o_out_vld,        1'b1);
                    check_val("dis_is_unary",   bus_dis.o_out_is_unary,   e.u);
                    check_val("dis_is_unary_n", bus_dis.o_out_is_unary_n, e.un);
                    check_val("dis_count",      bus_dis.o_out_count,      e.cnt);
                end
                if (gap_on && last_cyc >= 0) check_val("verdict_gap", cyc - last_cyc, 4);
                last_cyc = cyc;
            end
            if (abort) begin
                m_beat = 0;
                m_vec  = '0;
            end else if (in_vld && bus_en.o_in_rdy) begin
                m_vec[m_beat*BW +: BW] = in_dat;
                if (m_beat == NB - 1) begin
                    q_en.push_back(ref_verdict(m_vec, 1'b1));
                    q_dis.push_back(ref_verdict(m_vec, 1'b0));
                    m_beat = 0;
                    m_vec  = '0;
                end else begin
                    m_beat++;
                end
            end
        end
    end

    // present one beat and hold it until accepted; entered/left at posedge+1
    task automatic send_beat(input logic [BW-1:0] d);
        int n;
        n      = 0;
        in_vld = 1'b1;
        in_dat = d;
        @(negedge clk);
        while (!bus_en.o_in_rdy && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!bus_en.o_in_rdy) check_val("rdy_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic send_vec(input logic [W-1:0] v);
        for (int k = 0; k < int'(NB); k++) send_beat(v[k*BW +: BW]);
    endtask

    task automatic check_reset_state();
        check_val("rst_out_vld",   bus_en.o_out_vld,        1'b0);
        check_val("rst_is_unary",  bus_en.o_out_is_unary,   1'b0);
        check_val("rst_is_unary_n",bus_en.o_out_is_unary_n, 1'b0);
        check_val("rst_count",     bus_en.o_out_count,      5'd0);
        check_val("rst_in_rdy",    bus_en.o_in_rdy,         1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [W-1:0] vecs [7];
        vecs = '{16'h00FF, 16'hFF00, 16'h0000, 16'hFFFF, 16'h00F7, 16'h0001, 16'h8000};

        rst_n   = 1'b0;
        in_vld  = 1'b0;
        in_dat  = '0;
        abort   = 1'b0;
        out_rdy = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reset_state();
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // back-to-back vectors, one verdict every 4 cycles
        gap_on = 1'b1;
        foreach (vecs[i]) send_vec(vecs[i]);
        in_vld = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        gap_on = 1'b0;

        // backpressure: verdict held, next beat stalled
        out_rdy = 1'b0;
        send_vec(16'h0003);
        in_vld = 1'b1;
        in_dat = 4'hF;
        repeat (4) begin
            @(negedge clk);
            check_val("bp_in_rdy",  bus_en.o_in_rdy,       1'b0);
            check_val("bp_out_vld", bus_en.o_out_vld,      1'b1);
            check_val("bp_count",   bus_en.o_out_count,    5'd2);
            check_val("bp_unary",   bus_en.o_out_is_unary, 1'b1);
        end
        @(posedge clk);
        #1;
        out_rdy = 1'b1;
        @(negedge clk);
        check_val("bp_release_rdy", bus_en.o_in_rdy, 1'b1);
        @(posedge clk);
        #1;
        send_vec(16'h000F);
        in_vld = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // abort with a beat in the same cycle drops it
        send_beat(4'hF);
        send_beat(4'h0);
        in_vld = 1'b1;
        in_dat = 4'hF;
        abort  = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        send_vec(16'h0001);
        in_vld = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // abort does not disturb a pending verdict
        out_rdy = 1'b0;
        send_vec(16'h0007);
        in_vld = 1'b0;
        abort  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        abort = 1'b0;
        @(negedge clk);
        check_val("abort_pend_vld",   bus_en.o_out_vld,   1'b1);
        check_val("abort_pend_count", bus_en.o_out_count, 5'd3);
        @(posedge clk);
        #1;
        out_rdy = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // async reset while a verdict is pending
        out_rdy = 1'b0;
        send_vec(16'h003F);
        in_vld = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_state();
        @(negedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // async reset mid-vector discards the partial beats
        out_rdy = 1'b1;
        send_beat(4'hF);
        send_beat(4'hF);
        in_vld = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_state();
        @(negedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_vec(16'h0007);
        in_vld = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        check_val("sb_drain_en",  q_en.size(),  0);
        check_val("sb_drain_dis", q_dis.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/c_unary_stream.md
# c_unary_stream

Multi-beat unary (thermometer) code detector. Accepts a P_W-bit vector serialised into P_BEAT_W-bit beats, LSB beat first, and accumulates edge state across beats. Once the vector is complete, it returns a registered verdict: is the vector a unary code, is it a complemented unary code, and what is the run length. It sits in the c_ admission path wherever the vector is wider than a single-cycle cell chain can check, and uses valid/ready handshakes on both sides.

## Interface
- P_W, 32, total vector width; must be a multiple of P_BEAT_W and at least 2.
- P_BEAT_W, 8, bits per beat; the number of beats per vector is N = P_W/P_BEAT_W (N ≥ 1).
- P_ADMIT_COMPLIMENT_EN, 1, enables detection of complemented unary codes.
- clk  in  1  clock; all state updates on the rising edge.
- arst_n  in  1  reset, asynchronous assert, active-low.
- i_in_vld  in  1  beat valid.
- o_in_rdy  out  1  beat ready; equals ~o_out_vld | i_out_rdy (combinational).
- i_in_dat  in  P_W/N  beat data; beat k carries vector bits [k·P_BEAT_W +: P_BEAT_W].
- i_abort  in  1  synchronous discard of the partially received vector.
- o_out_vld  out  1  verdict valid.
- i_out_rdy  in  1  verdict accepted.
- o_out_is_unary  out  1  vector is of the form 0…01…1 (ones in the LSBs, k in 0..P_W).
- o_out_is_unary_n  out  1  vector is of the form 1…10…0; forced to 0 when P_ADMIT_COMPLIMENT_EN=0.
- o_out_count  out  $clog2(P_W+1)  run length (see Operation).

## Operation
- Accumulator state:
  - beat counter `beat_q`, 0..N-1.
  - Unary tracking: `seen0_q` (a 0 bit has been seen), `bad_q` (a 1 bit appeared after a 0), `cnt1_q` (count of leading ones).
  - Complement tracking: `seen1_q`, `bad_n_q`, `cnt0_q`, defined symmetrically.
- Per accepted beat, the bits are scanned LSB→MSB through a combinational chain, seeded from the accumulator:
  - Unary: a 1 with seen0 set sets bad. A 0 sets seen0. A 1 with seen0 clear increments cnt1.
  - Complement: the same rules with the bit values swapped.
- Beat accept happens when i_in_vld & o_in_rdy & ~i_abort.
  - If beat_q < N-1, the accumulator updates and beat_q increments.
  - If beat_q = N-1, the verdict is computed from the accumulator plus the current beat and written to the output register. o_out_vld is set, and the accumulator clears to its reset value (beat_q = 0).
- Verdict rules:
  - is_unary = ~bad.
  - is_unary_n = ~bad_n & P_ADMIT_COMPLIMENT_EN.
  - count = cnt1 if is_unary; else cnt0 if is_unary_n; else 0.
  - Unary takes priority. All-zeros gives 1/1/0; all-ones gives 1/1/P_W (is_unary_n reads 0 when the parameter is 0).
- Output register:
  - o_out_vld clears on i_out_rdy when no new final beat is accepted in the same cycle.
  - When a final beat is accepted in the same cycle as i_out_rdy, the register reloads and o_out_vld stays 1.
  - Verdict fields are held stable while o_out_vld & ~i_out_rdy.
- i_abort:
  - Clears the accumulator; any beat presented in the same cycle is discarded.
  - Does not affect the output register.
  - Abort with beat_q = 0 is a no-op.
- Reset (async, arst_n=0):
  - Clears the accumulator, sets o_out_vld = 0, and zeroes all verdict fields; o_in_rdy reads 1.
  - Reset in the middle of a vector discards the partial vector; the next accepted beat is beat 0.
- With N=1, every accepted beat produces a verdict.

## Timing
- Throughput is one beat per cycle. A verdict is produced every N cycles with no bubbles while i_out_rdy stays high.
- Latency: o_out_vld rises on the clock edge that accepts the final beat, so it is visible the cycle after that beat.
- Backpressure: with o_out_vld=1 and i_out_rdy=0, o_in_rdy=0. Beats stall, and the accumulator holds even while i_in_vld=1.
- Held-beat rule: i_in_dat must be held while i_in_vld & ~o_in_rdy; the block does not check this.
- Combinational paths:
  - i_out_rdy → o_in_rdy is the only input-to-output combinational path.
  - The verdict outputs are registered.
  - Beat scan depth is P_BEAT_W cells plus the count adder.

## Test plan
- Unary vector, P_W=16, P_BEAT_W=4: beats 0xF,0xF,0x0,0x0 (vector 0x00FF) → one cycle after beat 3, o_out_vld=1, is_unary=1, is_unary_n=0, count=8.
- Complemented vector 0xFF00 (beats 0x0,0x0,0xF,0xF):
  - P_ADMIT_COMPLIMENT_EN=1 → 0/1/8.
  - P_ADMIT_COMPLIMENT_EN=0 → 0/0/0.
- Boundary and invalid vectors:
  - 0x0000 → 1/1/0.
  - 0xFFFF → 1/1/16.
  - 0x00F7 (hole in the ones run) → 0/0/0.
  - 0x0001 → 1/0/1.
  - 0x8000 → 0/1/15.
- Backpressure: hold i_out_rdy=0 after the first verdict while streaming a second vector.
  - o_in_rdy=0 throughout; the first verdict is stable and the second vector's beats are not consumed.
  - Raise i_out_rdy: the first verdict is accepted and the second vector's beat 0 is accepted in the same cycle.
  - Continuous back-to-back vectors with i_out_rdy=1 → o_out_vld pulses on every 4th cycle.
- Abort: send 0xF,0x0, then assert i_abort together with beat 0xF.
  - The beat is dropped and beat_q=0.
  - Next send 0x1,0x0,0x0,0x0 → 1/0/1.
  - A verdict that was already pending is unaffected by the abort.
- Reset mid-vector: assert arst_n=0 asynchronously after 2 beats while o_out_vld=1.
  - o_out_vld drops immediately, all fields read 0 and o_in_rdy=1.
  - After release, vector 0x0007 → 1/0/3.
